// File: rtl/partitioned_subtractor_pipe.sv
// Two-stage lane-partitioned subtractor (diff = a - b - bin) for 1x64, 2x32 or 4x16 lanes.
// Low half is resolved in stage 1 and high half in stage 2; the ready chain is combinational with no skid buffer.
module partitioned_subtractor_pipe #(
  parameter int LANE_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [4*LANE_W-1:0] a,
  input  logic [4*LANE_W-1:0] b,
  input  logic                bin,
  input  logic [1:0]          mode,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [4*LANE_W-1:0] diff,
  output logic [3:0]          lane_borrow,
  output logic [3:0]          lane_zero
);
  localparam int W = 4 * LANE_W;
  localparam int H = 2 * LANE_W;

  // Returns {borrow_out, difference} for one LANE_W chunk.
  function automatic logic [LANE_W:0] sub_lane(input logic [LANE_W-1:0] x,
                                               input logic [LANE_W-1:0] y,
                                               input logic              bi);
    sub_lane = {1'b0, x} - {1'b0, y} - {{LANE_W{1'b0}}, bi};
  endfunction

  logic              r_s1_valid;
  logic [H-1:0]      r_s1_dlo;
  logic [1:0]        r_s1_bor;
  logic [1:0]        r_s1_zero;
  logic [H-1:0]      r_s1_ahi;
  logic [H-1:0]      r_s1_bhi;
  logic [1:0]        r_s1_mode;
  logic              r_s1_bin;
  logic              r_s1_cmid;

  logic              r_s2_valid;
  logic [W-1:0]      r_diff;
  logic [3:0]        r_lane_borrow;
  logic [3:0]        r_lane_zero;

  logic              w_s1_ready;
  logic              w_s2_ready;
  logic [LANE_W:0]   w_l0;
  logic [LANE_W:0]   w_l1;
  logic [LANE_W:0]   w_l2;
  logic [LANE_W:0]   w_l3;
  logic              w_bin1;
  logic              w_bin2;
  logic              w_bin3;

  assign w_s2_ready = !r_s2_valid || out_ready;
  assign w_s1_ready = !r_s1_valid || w_s2_ready;
  assign in_ready   = w_s1_ready;

  // Modes 0 and 1 chain across the 16-bit boundary inside a 32-bit half; modes 2 and 3 restart with bin.
  assign w_bin1 = mode[1] ? bin : w_l0[LANE_W];
  assign w_l0   = sub_lane(a[LANE_W-1:0], b[LANE_W-1:0], bin);
  assign w_l1   = sub_lane(a[H-1:LANE_W], b[H-1:LANE_W], w_bin1);

  // Only the single 64-bit lane carries the mid borrow across bit 32.
  assign w_bin2 = (r_s1_mode == 2'd0) ? r_s1_cmid : r_s1_bin;
  assign w_bin3 = r_s1_mode[1] ? r_s1_bin : w_l2[LANE_W];
  assign w_l2   = sub_lane(r_s1_ahi[LANE_W-1:0], r_s1_bhi[LANE_W-1:0], w_bin2);
  assign w_l3   = sub_lane(r_s1_ahi[H-1:LANE_W], r_s1_bhi[H-1:LANE_W], w_bin3);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_dlo   <= '0;
      r_s1_bor   <= '0;
      r_s1_zero  <= '0;
      r_s1_ahi   <= '0;
      r_s1_bhi   <= '0;
      r_s1_mode  <= '0;
      r_s1_bin   <= 1'b0;
      r_s1_cmid  <= 1'b0;
    end else if (w_s1_ready) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_dlo  <= {w_l1[LANE_W-1:0], w_l0[LANE_W-1:0]};
        r_s1_bor  <= {w_l1[LANE_W], w_l0[LANE_W]};
        r_s1_zero <= {w_l1[LANE_W-1:0] == '0, w_l0[LANE_W-1:0] == '0};
        r_s1_ahi  <= a[W-1:H];
        r_s1_bhi  <= b[W-1:H];
        r_s1_mode <= mode;
        r_s1_bin  <= bin;
        r_s1_cmid <= w_l1[LANE_W];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s2_valid    <= 1'b0;
      r_diff        <= '0;
      r_lane_borrow <= '0;
      r_lane_zero   <= '0;
    end else if (w_s2_ready) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_diff        <= {w_l3[LANE_W-1:0], w_l2[LANE_W-1:0], r_s1_dlo};
        r_lane_borrow <= {w_l3[LANE_W], w_l2[LANE_W], r_s1_bor};
        r_lane_zero   <= {w_l3[LANE_W-1:0] == '0, w_l2[LANE_W-1:0] == '0, r_s1_zero};
      end
    end
  end

  assign out_valid   = r_s2_valid;
  assign diff        = r_diff;
  assign lane_borrow = r_lane_borrow;
  assign lane_zero   = r_lane_zero;

endmodule

// File: tb/tb_partitioned_subtractor_pipe.sv
// Directed bench for partitioned_subtractor_pipe: lane modes, borrow/zero flags, stalls and async reset.
module tb_partitioned_subtractor_pipe;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] a;
  logic [63:0] b;
  logic        bin;
  logic [1:0]  mode;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] diff;
  logic [3:0]  lane_borrow;
  logic [3:0]  lane_zero;

  int checks = 0;
  int errors = 0;

  partitioned_subtractor_pipe #(.LANE_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .bin(bin), .mode(mode), .out_valid(out_valid), .out_ready(out_ready), .diff(diff),
    .lane_borrow(lane_borrow), .lane_zero(lane_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One isolated beat: accept, no result one cycle later, result the cycle after.
  task automatic beat(input string tag, input logic [63:0] ta, input logic [63:0] tb_v,
                      input logic tbin, input logic [1:0] tmode,
                      input logic [63:0] ediff, input logic [3:0] elb, input logic [3:0] elz);
    @(negedge clk);
    a = ta; b = tb_v; bin = tbin; mode = tmode; in_valid = 1'b1; out_ready = 1'b1;
    #1 chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    chk({tag, "_valid_early"}, 64'(out_valid), 64'd0);
    @(negedge clk);
    chk({tag, "_valid"}, 64'(out_valid), 64'd1);
    chk({tag, "_diff"}, diff, ediff);
    chk({tag, "_borrow"}, 64'(lane_borrow), 64'(elb));
    chk({tag, "_zero"}, 64'(lane_zero), 64'(elz));
  endtask

  initial begin
    logic [3:0] pat;
    int sent;
    int rcvd;
    int cyc;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; bin = 1'b0; mode = 2'd0;
    #12;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_diff", diff, 64'd0);
    chk("rst_borrow", 64'(lane_borrow), 64'd0);
    chk("rst_zero", 64'(lane_zero), 64'd0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);

    beat("t1_m0", 64'h0, 64'h1, 1'b0, 2'd0, 64'hFFFF_FFFF_FFFF_FFFF, 4'b1111, 4'b0000);
    beat("t2_m1", 64'h0000_0005_0000_0000, 64'h0000_0001_0000_0001, 1'b0, 2'd1,
         64'h0000_0004_FFFF_FFFF, 4'b0011, 4'b1000);
    beat("t3_m2", 64'h0001_0000_8000_1234, 64'h0001_0001_8000_1234, 1'b0, 2'd2,
         64'h0000_FFFF_0000_0000, 4'b0100, 4'b1011);
    beat("t5_m2_bin", 64'h0001_0001_0001_0001, 64'h0001_0001_0001_0001, 1'b1, 2'd2,
         64'hFFFF_FFFF_FFFF_FFFF, 4'b1111, 4'b0000);
    beat("m3_as_4x16", 64'h0000_0001_0000_0000, 64'h0000_0000_0000_0001, 1'b0, 2'd3,
         64'h0000_0001_0000_FFFF, 4'b0001, 4'b1010);
    beat("m0_chain", 64'h0000_0001_0000_0000, 64'h0000_0000_0000_0001, 1'b0, 2'd0,
         64'h0000_0000_FFFF_FFFF, 4'b0011, 4'b1100);

    // Stream of 8 beats, out_ready pattern 1,0,0,1; beat i: (0x100+i) - 1 in mode 0.
    pat = 4'b1001;
    sent = 0; rcvd = 0; cyc = 0;
    while (rcvd < 8 && cyc < 100) begin
      @(negedge clk);
      out_ready = pat[cyc % 4];
      in_valid  = (sent < 8);
      a = 64'h100 + 64'(sent); b = 64'h1; bin = 1'b0; mode = 2'd0;
      #1;
      chk("stream_in_ready", 64'(in_ready), 64'(!((sent - rcvd) == 2 && !out_ready)));
      if (out_valid) begin
        chk("stream_diff", diff, 64'hFF + 64'(rcvd));
        chk("stream_zero", 64'(lane_zero), 64'b1110);
        if (out_ready) rcvd++;
      end
      if (in_valid && in_ready) sent++;
      cyc++;
    end
    chk("stream_count", 64'(rcvd), 64'd8);
    @(negedge clk); in_valid = 1'b0; out_ready = 1'b1;

    // Two beats in flight, then asynchronous reset.
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; a = 64'h5; b = 64'h1; mode = 2'd0; bin = 1'b0;
    @(negedge clk); a = 64'h9;
    @(negedge clk); in_valid = 1'b0;
    chk("flight_valid", 64'(out_valid), 64'd1);
    #2 rst = 1'b1;
    #1 chk("async_rst_valid", 64'(out_valid), 64'd0);
    @(negedge clk); rst = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("no_stale", 64'(out_valid), 64'd0);
    end
    beat("t6_after_rst", 64'h0001_0000_8000_1234, 64'h0001_0001_8000_1234, 1'b0, 2'd2,
         64'h0000_FFFF_0000_0000, 4'b0100, 4'b1011);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
